ntt_stage_sched: RTL and testbench

- Upstream/downstream scheduler for the NTT2 butterfly pipeline.
- Holds one N-point coefficient buffer and walks all LOGN Cooley-Tukey (DIT) stages.
- For each butterfly it issues one coefficient pair plus its twiddle into the butterfly and writes the returned xout/yout back in place.
- Input is loaded in bit-reversed order; output is read back in natural order.

---
 rtl/ntt_stage_sched.sv | 177 +++++++++++++++++
 tb/tb_ntt_stage_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_stage_sched.sv
// ntt_stage_sched: in-place radix-2 DIT NTT scheduler
// for an external pipelined butterfly.
`timescale 1ns/1ps
`ifndef Datawidth
`define Datawidth 16
`endif
`ifndef PRIME
`define PRIME 65537
`endif

module ntt_stage_sched #(
  parameter int N          = 256,
  parameter int LOGN       = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_we,
  input  logic [LOGN-1:0]     ld_addr,
  input  logic [`Datawidth:0] ld_data,
  output logic [`Datawidth:0] rd_data,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [LOGN-2:0]     tw_addr,
  input  logic [`Datawidth:0] tw_data,
  output logic                bf_en,
  output logic [`Datawidth:0] bf_x,
  output logic [`Datawidth:0] bf_y,
  output logic [`Datawidth:0] bf_w,
  input  logic [`Datawidth:0] bf_xout,
  input  logic [`Datawidth:0] bf_yout,
  input  logic                bf_valid
);

  localparam int DW = `Datawidth + 1;
  localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int KW = LOGN - 1;
  localparam int PW =
    (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } state_t;

  state_t        state;
  logic [SW-1:0] stage;
  logic [KW-1:0] k;
  logic [CW-1:0] cnt;
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  logic [DW-1:0]   mem   [N];
  logic [LOGN-1:0] q_top [FIFO_DEPTH];
  logic [LOGN-1:0] q_bot [FIFO_DEPTH];

  logic [LOGN-1:0] kx;
  logic [LOGN-1:0] m;
  logic [LOGN-1:0] mask;
  logic [LOGN-1:0] top;
  logic [LOGN-1:0] bot;
  logic [KW-1:0]   twk;
  logic [SW-1:0]   twsh;
  logic            issue;
  logic            pop;

  always_comb begin
    kx   = {1'b0, k};
    m    = LOGN'(1) << stage;
    mask = m - LOGN'(1);
    top  = (((kx >> stage) << stage) << 1)
         | (kx & mask);
    bot  = top | m;
    twk  = k & mask[KW-1:0];
    twsh = SW'(LOGN - 1) - stage;
    tw_addr = twk << twsh;
  end

  assign issue = (state == ISSUE)
              && (cnt < CW'(FIFO_DEPTH));
  assign pop   = bf_valid && (cnt != '0);

  assign bf_en   = issue;
  assign bf_x    = issue ? mem[top] : '0;
  assign bf_y    = issue ? mem[bot] : '0;
  assign bf_w    = issue ? tw_data  : '0;
  assign rd_data = mem[ld_addr];

  always_ff @(posedge clk) begin
    if (pop) begin
      mem[q_top[rp]] <= bf_xout;
      mem[q_bot[rp]] <= bf_yout;
    end else if (ld_we && !busy) begin
      mem[ld_addr] <= ld_data;
    end
    if (issue) begin
      q_top[wp] <= top;
      q_bot[wp] <= bot;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      stage <= '0;
      k     <= '0;
      cnt   <= '0;
      wp    <= '0;
      rp    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;

      if (issue) begin
        wp <= (wp == PW'(FIFO_DEPTH - 1))
            ? '0 : wp + PW'(1);
      end
      if (pop) begin
        rp <= (rp == PW'(FIFO_DEPTH - 1))
            ? '0 : rp + PW'(1);
      end
      if (issue && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (!issue && pop) begin
        cnt <= cnt - CW'(1);
      end

      if (bf_valid && (cnt == '0)) begin
        err <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state <= ISSUE;
            stage <= '0;
            k     <= '0;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue) begin
            if (k == KW'(N / 2 - 1)) begin
              state <= DRAIN;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            if (stage == SW'(LOGN - 1)) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
              stage <= stage + SW'(1);
              k     <= '0;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_stage_sched.sv
// tb_ntt_stage_sched: NTT runs vs direct DFT,
// fixed-latency butterfly, stall/abort/err cases.
`timescale 1ns/1ps
`ifndef Datawidth
`define Datawidth 16
`endif
`ifndef PRIME
`define PRIME 65537
`endif

module tb_ntt_stage_sched;

  localparam int N    = 8;
  localparam int LOGN = 3;
  localparam int FD   = 2;
  localparam int LAT  = 4;
  localparam int DW   = `Datawidth + 1;
  localparam longint P = `PRIME;

  logic            clk;
  logic            reset;
  logic            ld_we;
  logic [LOGN-1:0] ld_addr;
  logic [DW-1:0]   ld_data;
  logic [DW-1:0]   rd_data;
  logic            start;
  logic            busy;
  logic            done;
  logic            err;
  logic [LOGN-2:0] tw_addr;
  logic [DW-1:0]   tw_data;
  logic            bf_en;
  logic [DW-1:0]   bf_x;
  logic [DW-1:0]   bf_y;
  logic [DW-1:0]   bf_w;
  logic [DW-1:0]   bf_xout;
  logic [DW-1:0]   bf_yout;
  logic            bf_valid;
  logic            spur;

  logic          pv  [LAT];
  logic [DW-1:0] px  [LAT];
  logic [DW-1:0] py  [LAT];
  logic [DW-1:0] rom [N/2];
  longint        wpow [N];

  logic [DW-1:0]   a_nat [N];
  logic [DW-1:0]   xr [N];
  logic [3*DW-1:0] obs [$];
  logic [3*DW-1:0] expq [$];

  int n_chk;
  int n_err;
  int n_iss;
  int n_ret;
  int max_out;
  int stall_bad;
  int nz_bad;
  int done_cnt;
  int done_bad;
  int n_runs;
  logic done_prev;

  assign bf_valid = pv[LAT-1] | spur;
  assign bf_xout  = px[LAT-1];
  assign bf_yout  = py[LAT-1];
  assign tw_data  = rom[tw_addr];

  ntt_stage_sched #(
    .N(N),
    .LOGN(LOGN),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ld_we(ld_we),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .rd_data(rd_data),
    .start(start),
    .busy(busy),
    .done(done),
    .err(err),
    .tw_addr(tw_addr),
    .tw_data(tw_data),
    .bf_en(bf_en),
    .bf_x(bf_x),
    .bf_y(bf_y),
    .bf_w(bf_w),
    .bf_xout(bf_xout),
    .bf_yout(bf_yout),
    .bf_valid(bf_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint mulm(
    input longint a, input longint b);
    return (a * b) % P;
  endfunction

  function automatic longint powm(
    input longint b, input int e);
    longint r;
    r = 1;
    repeat (e) r = mulm(r, b);
    return r;
  endfunction

  function automatic logic [LOGN-1:0] brev(
    input int i);
    logic [LOGN-1:0] r;
    logic [LOGN-1:0] iv;
    iv = LOGN'(i);
    for (int b = 0; b < LOGN; b++)
      r[b] = iv[LOGN-1-b];
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h",
               tag, got, want);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    longint wy;
    if (!reset) begin
      for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
    end else begin
      wy = mulm(longint'(bf_w), longint'(bf_y));
      pv[0] <= bf_en;
      px[0] <= DW'((longint'(bf_x) + wy) % P);
      py[0] <= DW'((longint'(bf_x) + P - wy) % P);
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        px[i] <= px[i-1];
        py[i] <= py[i-1];
      end
    end
  end

  always @(negedge clk) begin
    int outst;
    if (!reset) begin
      n_iss = 0;
      n_ret = 0;
      done_prev = 1'b0;
    end else begin
      outst = n_iss - n_ret;
      if (outst > max_out) max_out = outst;
      if (bf_en) begin
        if (outst >= FD) stall_bad++;
        obs.push_back({bf_x, bf_y, bf_w});
        n_iss++;
      end else if ((bf_x | bf_y | bf_w) != '0) begin
        nz_bad++;
      end
      if (pv[LAT-1]) n_ret++;
      if (done) begin
        done_cnt++;
        if (busy || done_prev) done_bad++;
      end
      done_prev = done;
    end
  end

  task automatic load_vec();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      ld_we   = 1'b1;
      ld_addr = brev(i);
      ld_data = a_nat[i];
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic build_expect();
    longint v [N];
    longint s;
    longint wy;
    longint nt;
    int m;
    int t;
    int b;
    expq.delete();
    for (int r = 0; r < N; r++)
      v[r] = longint'(a_nat[brev(r)]);
    for (int st = 0; st < LOGN; st++) begin
      m = 1 << st;
      for (int g = 0; g < N; g += 2 * m) begin
        for (int j = 0; j < m; j++) begin
          t = g + j;
          b = t + m;
          expq.push_back({DW'(v[t]), DW'(v[b]),
            DW'(wpow[j * (N / (2 * m))])});
          wy = mulm(wpow[j * (N / (2 * m))], v[b]);
          nt = (v[t] + wy) % P;
          v[b] = (v[t] + P - wy) % P;
          v[t] = nt;
        end
      end
    end
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int i = 0; i < N; i++) begin
        s = (s + mulm(longint'(a_nat[i]),
                      wpow[(i * j) % N])) % P;
      end
      xr[j] = DW'(s);
    end
  endtask

  task automatic readback(input string tag);
    for (int j = 0; j < N; j++) begin
      ld_addr = LOGN'(j);
      #1;
      chk(tag, 64'(rd_data), 64'(xr[j]));
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag);
    logic got;
    load_vec();
    build_expect();
    obs.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk({tag, "_done"}, 64'(got), 64'(1));
    n_runs++;
    chk({tag, "_bf_en_count"}, 64'(obs.size()),
        64'(LOGN * N / 2));
    for (int i = 0; i < expq.size(); i++) begin
      chk({tag, "_issue"},
          (i < obs.size()) ? 64'(obs[i]) : 64'(0),
          64'(expq[i]));
    end
    chk({tag, "_err"}, 64'(err), 64'(0));
    readback({tag, "_rd"});
  endtask

  task automatic rand_vec();
    for (int i = 0; i < N; i++)
      a_nat[i] = DW'($urandom % 32'(P));
  endtask

  initial begin
    longint wn;
    int d0;
    n_chk = 0;
    n_err = 0;
    max_out = 0;
    stall_bad = 0;
    nz_bad = 0;
    done_cnt = 0;
    done_bad = 0;
    n_runs = 0;
    reset = 1'b0;
    ld_we = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    start = 1'b0;
    spur = 1'b0;
    wn = powm(3, int'((P - 1) / N));
    for (int e = 0; e < N; e++) wpow[e] = powm(wn, e);
    for (int e = 0; e < N / 2; e++) rom[e] = DW'(wpow[e]);

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_bf_en", 64'(bf_en), 64'(0));

    for (int i = 0; i < N; i++) a_nat[i] = '0;
    run("zeros");
    for (int i = 0; i < N; i++)
      a_nat[i] = (i == 0) ? DW'(1) : DW'(0);
    run("delta");
    for (int i = 0; i < N; i++) a_nat[i] = DW'(1);
    run("ones");
    for (int r = 0; r < 3; r++) begin
      rand_vec();
      run("rand");
    end
    for (int i = 0; i < N; i++) a_nat[i] = DW'(P - 1);
    run("max");

    rand_vec();
    load_vec();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_bf_en", 64'(bf_en), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    rand_vec();
    run("after_abort");

    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    #1;
    chk("spur_err", 64'(err), 64'(1));
    repeat (5) @(negedge clk);
    chk("spur_err_sticky", 64'(err), 64'(1));
    readback("spur_rd");

    chk("max_outstanding", 64'(max_out), 64'(FD));
    chk("stall_violations", 64'(stall_bad), 64'(0));
    chk("idle_operands_zero", 64'(nz_bad), 64'(0));
    chk("done_shape", 64'(done_bad), 64'(0));
    chk("done_total", 64'(done_cnt), 64'(n_runs));

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
